mac_feeder_parallel_16: RTL and testbench
=========================================

# mac_feeder_parallel_16

Operand sequencer directly upstream of the two-lane parallel 16-bit MAC (`mac_unit_Parallel_16` core, unregistered inputs). It accepts a dot-product command (element count plus bias), pulls act/weight element pairs from a valid/ready stream, and drives the MAC lanes, `en`, `load_accum` and `accum_prev`. It accounts for the MAC's internal psum register, so the bias is folded in at the correct cycle and the last psum is drained. It then pulses `done` in the cycle the MAC accumulator holds the finished vector result.

## Interface
- DATA_WIDTH, 8, operand width (matches MAC)
- ACC_WIDTH, DATA_WIDTH+16, MAC accumulator width
- LEN_WIDTH, 12, width of element-count field
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; accepted only when busy=0
- vec_len  in  LEN_WIDTH  element count of the dot product; 0 is legal
- bias  in  ACC_WIDTH  signed initial accumulator value
- busy  out  1  command in progress
- in_valid  in  1  input beat valid
- in_ready  out  1  feeder accepts a beat this cycle
- in_act  in  2×DATA_WIDTH  signed elements for lanes 0 and 1; lane 0 is the earlier element
- in_w  in  2×DATA_WIDTH  signed weights for lanes 0 and 1
- mac_en  out  1  to MAC `en`
- mac_load_accum  out  1  to MAC `load_accum`
- mac_act  out  2×DATA_WIDTH  to MAC `act_in`
- mac_w  out  2×DATA_WIDTH  to MAC `w_in`
- mac_accum_prev  out  ACC_WIDTH  to MAC `accum_prev`; equals the latched bias
- done  out  1  one-cycle pulse; MAC accumulator holds the result

## Operation
- State machine has four states: IDLE, RUN, DRAIN, FIN.
- IDLE with start=1:
  - latch vec_len and bias.
  - set pairs_left = ceil(vec_len/2); set odd flag = vec_len[0].
  - go to RUN.
- RUN, vec_len≠0:
  - in_ready=1.
  - A beat is accepted when in_valid&in_ready. mac_en=1 in exactly the accepted cycles. mac_act/mac_w = in_act/in_w, combinational pass-through.
  - On the final beat with the odd flag set, lane 1 act and w are forced to 0.
  - pairs_left decrements per beat. After the final beat, go to DRAIN.
  - in_valid=0 gives mac_en=0, which freezes the MAC.
- RUN, vec_len=0: in_ready=0. Issue one synthetic beat (mac_en=1, all lanes 0), then go to DRAIN. No input is consumed.
- DRAIN:
  - mac_en=1, lanes 0; this folds the last psum into the accumulator.
  - go to FIN.
- FIN: done=1, busy=0, return to IDLE. start is accepted in FIN, equivalent to IDLE.
- mac_load_accum=1 on exactly the second mac_en cycle of each command; this may be the DRAIN cycle. At that edge, psum_reg holds pair 0's psum, so accumulator = bias + psum0.
  - A registered "first issued" flag tracks this.
- mac_en=0 and lanes 0 whenever not issuing. busy = (state is RUN or DRAIN).
- Result definition: MAC accumulator = bias + Σ act_i·w_i over vec_len elements, computed in ACC_WIDTH with wrap-around. The feeder does no saturation.
- start while busy=1 is ignored. A command is never queued.

## Timing
- Reset (asynchronous assert, synchronous deassert by system):
  - state=IDLE; counters and flags 0; latched bias 0.
  - busy, in_ready, mac_en, mac_load_accum, done = 0; mac_act, mac_w, mac_accum_prev = 0.
- Reset during RUN/DRAIN abandons the command. The MAC is reset separately. No done is issued.
- Start accepted in cycle S with no stalls, P = max(ceil(vec_len/2), 1):
  - issue cycles S+1 … S+P.
  - DRAIN at S+P+1.
  - done at S+P+2.
  - The MAC accumulator is valid from S+P+2 until the next mac_en.
- Each stall cycle (in_valid=0 in RUN) adds exactly one cycle to all subsequent events.
- Back-to-back: start asserted in the FIN cycle gives the next issue at FIN+1. Steady state costs 2 overhead cycles per command.
- in_ready has no combinational dependence on in_valid.

## Test plan
- vec_len=8, bias=0, no stalls, beats (1,2),(3,4) / (5,6),(7,8) / (-1,1),(2,2) / (0,9),(4,−3):
  - required: accum = 2+12+30+56−1+4+0−12 = 91.
  - required: done at S+6 (P=4).
  - required: mac_load_accum high only at S+2.
- vec_len=3, bias=1000, beats (10,10),(2,3) / (4,5),(0x7F,0x7F):
  - lane 1 of the last beat is masked to 0.
  - required: accum = 1126; done at S+4; load_accum at S+2.
- vec_len=1, bias=−5, beat (−8,7),(x,x):
  - required: load_accum in the DRAIN cycle (S+2); accum = −61; done at S+3.
- vec_len=0, bias=42:
  - required: no input accepted (in_ready stays 0); accum = 42; done at S+3.
- vec_len=4 with in_valid low for 3 cycles between beats:
  - required: mac_en low during the stall; result is identical to the unstalled run; done delayed exactly 3 cycles.
- reset_n pulled low mid-RUN:
  - required: all outputs 0 immediately; no done.
  - required: a subsequent start, vec_len=2, beat (3,3),(3,3), bias 0 yields accum 18.

Source files
------------

// File: rtl/mac_feeder_parallel_16.sv
// Operand sequencer for the two-lane parallel 16-bit MAC.
// Takes a dot-product command (element count + bias), streams act/weight pairs
// into the MAC lanes, folds the bias in on the second issue cycle (when the MAC
// psum register holds pair 0's product), drains the last psum, then pulses done.
module mac_feeder_parallel_16 #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = DATA_WIDTH + 16,
    parameter int unsigned LEN_WIDTH  = 12
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    vec_len,
    input  logic [ACC_WIDTH-1:0]    bias,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] in_act,
    input  logic [2*DATA_WIDTH-1:0] in_w,
    output logic                    mac_en,
    output logic                    mac_load_accum,
    output logic [2*DATA_WIDTH-1:0] mac_act,
    output logic [2*DATA_WIDTH-1:0] mac_w,
    output logic [ACC_WIDTH-1:0]    mac_accum_prev,
    output logic                    done
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StFin
    } state_e;

    state_e                 r_state;
    logic [LEN_WIDTH-1:0]   r_pairs_left;
    logic                   r_odd;
    logic                   r_zero_len;
    logic                   r_first_issued;
    logic                   r_load_done;
    logic [ACC_WIDTH-1:0]   r_bias;

    logic                   w_accept_cmd;
    logic                   w_beat;
    logic                   w_synth;
    logic                   w_issue;
    logic                   w_last_beat;
    logic                   w_load;
    logic [LEN_WIDTH-1:0]   w_pairs_init;

    // Decode the issue conditions from the current state and the input handshake
    always_comb begin
        w_accept_cmd = start && ((r_state == StIdle) || (r_state == StFin));
        // ceil(len/2) without a carry-out bit: max value 2^(LEN_WIDTH-1) fits
        w_pairs_init = (vec_len >> 1) + LEN_WIDTH'(vec_len[0]);
        w_beat       = (r_state == StRun) && !r_zero_len && in_valid;
        w_synth      = (r_state == StRun) && r_zero_len;
        w_issue      = w_beat || w_synth || (r_state == StDrain);
        w_last_beat  = w_beat && (r_pairs_left == LEN_WIDTH'(1));
        // Second issue of the command: psum_reg then holds pair 0's product
        w_load       = w_issue && r_first_issued && !r_load_done;
    end

    // Drive the MAC lanes: pass-through on real beats, zeros otherwise
    always_comb begin
        busy           = (r_state == StRun) || (r_state == StDrain);
        in_ready       = (r_state == StRun) && !r_zero_len;
        done           = (r_state == StFin);
        mac_en         = w_issue;
        mac_load_accum = w_load;
        mac_accum_prev = r_bias;
        mac_act        = '0;
        mac_w          = '0;
        if (w_beat) begin
            mac_act[DATA_WIDTH-1:0] = in_act[DATA_WIDTH-1:0];
            mac_w[DATA_WIDTH-1:0]   = in_w[DATA_WIDTH-1:0];
            // Odd-length vectors: the trailing lane 1 element does not exist
            if (!(w_last_beat && r_odd)) begin
                mac_act[2*DATA_WIDTH-1:DATA_WIDTH] = in_act[2*DATA_WIDTH-1:DATA_WIDTH];
                mac_w[2*DATA_WIDTH-1:DATA_WIDTH]   = in_w[2*DATA_WIDTH-1:DATA_WIDTH];
            end
        end
    end

    // Command FSM with pair counter and issue-tracking flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= StIdle;
            r_pairs_left   <= '0;
            r_odd          <= 1'b0;
            r_zero_len     <= 1'b0;
            r_first_issued <= 1'b0;
            r_load_done    <= 1'b0;
            r_bias         <= '0;
        end else begin
            if (w_issue) begin
                r_first_issued <= 1'b1;
                if (w_load) begin
                    r_load_done <= 1'b1;
                end
            end
            unique case (r_state)
                StIdle, StFin: begin
                    if (w_accept_cmd) begin
                        r_pairs_left   <= w_pairs_init;
                        r_odd          <= vec_len[0];
                        r_zero_len     <= (vec_len == '0);
                        r_bias         <= bias;
                        r_first_issued <= 1'b0;
                        r_load_done    <= 1'b0;
                        r_state        <= StRun;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StRun: begin
                    if (w_synth) begin
                        r_state <= StDrain;
                    end else if (w_beat) begin
                        r_pairs_left <= r_pairs_left - LEN_WIDTH'(1);
                        if (w_last_beat) begin
                            r_state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    r_state <= StFin;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_feeder_parallel_16.sv
// Directed bench for mac_feeder_parallel_16 with a behavioural MAC downstream.
module tb_mac_feeder_parallel_16;

    localparam int DW = 8;
    localparam int AW = DW + 16;
    localparam int LW = 12;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic [LW-1:0]   vec_len;
    logic [AW-1:0]   bias;
    logic            busy;
    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] in_act;
    logic [2*DW-1:0] in_w;
    logic            mac_en;
    logic            mac_load_accum;
    logic [2*DW-1:0] mac_act;
    logic [2*DW-1:0] mac_w;
    logic [AW-1:0]   mac_accum_prev;
    logic            done;

    int n_vec = 0;
    int n_err = 0;

    mac_feeder_parallel_16 #(
        .DATA_WIDTH(DW),
        .ACC_WIDTH (AW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .vec_len       (vec_len),
        .bias          (bias),
        .busy          (busy),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_act        (in_act),
        .in_w          (in_w),
        .mac_en        (mac_en),
        .mac_load_accum(mac_load_accum),
        .mac_act       (mac_act),
        .mac_w         (mac_w),
        .mac_accum_prev(mac_accum_prev),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: registered psum, accumulator loads accum_prev + psum
    logic signed [2*DW-1:0] prod0, prod1;
    logic signed [AW-1:0]   m_p, m_psum, m_acc;
    always_comb begin
        prod0 = $signed(mac_act[DW-1:0]) * $signed(mac_w[DW-1:0]);
        prod1 = $signed(mac_act[2*DW-1:DW]) * $signed(mac_w[2*DW-1:DW]);
        m_p   = AW'(prod0) + AW'(prod1);
    end
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_psum <= '0;
            m_acc  <= '0;
        end else if (mac_en) begin
            m_psum <= m_p;
            m_acc  <= mac_load_accum ? ($signed(mac_accum_prev) + m_psum) : (m_acc + m_psum);
        end
    end

    // Event monitor sampled on the falling edge
    int cyc = 0;
    int s_cyc, done_cyc, first_done, load_cyc;
    int done_cnt, load_cnt, en_cnt, rdy_cnt;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (start && !busy) s_cyc = cyc;
        if (mac_load_accum) begin load_cnt++; load_cyc = cyc; end
        if (done) begin
            if (done_cnt == 0) first_done = cyc;
            done_cnt++;
            done_cyc = cyc;
        end
        if (in_ready) rdy_cnt++;
        if (mac_en) en_cnt++;
    end

    task automatic clear_mon();
        done_cnt = 0; load_cnt = 0; en_cnt = 0; rdy_cnt = 0;
        s_cyc = -100; done_cyc = -100; first_done = -100; load_cyc = -100;
    endtask

    logic [DW-1:0] ba0[4], bw0[4], ba1[4], bw1[4];

    task automatic set_beat(input int i, input logic [DW-1:0] a0, input logic [DW-1:0] w0,
                            input logic [DW-1:0] a1, input logic [DW-1:0] w1);
        ba0[i] = a0; bw0[i] = w0; ba1[i] = a1; bw1[i] = w1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, stream beats (optional stall before beat stall_at), wait for done
    task automatic do_cmd(input int len, input int b, input int nbeats,
                          input int stall_at, input int stall_n);
        clear_mon();
        start = 1'b1; vec_len = LW'(len); bias = AW'(b);
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (i == stall_at) begin
                in_valid = 1'b0;
                repeat (stall_n) next_cycle();
            end
            in_valid = 1'b1;
            in_act = {ba1[i], ba0[i]};
            in_w   = {bw1[i], bw0[i]};
            next_cycle();
        end
        in_valid = 1'b0; in_act = '0; in_w = '0;
        for (int k = 0; k < 20 && done_cnt == 0; k++) next_cycle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 1'b1; in_act = 16'hFFFF; in_w = 16'hFFFF;
        #1;
        n_vec++;
        if ({busy, in_ready, mac_en, mac_load_accum, done} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 00000",
                              {busy, in_ready, mac_en, mac_load_accum, done});
        end
        n_vec++;
        if ({mac_act, mac_w, mac_accum_prev} !== '0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", {mac_act, mac_w, mac_accum_prev});
        end
        in_valid = 1'b0; in_act = '0; in_w = '0;
        repeat (2) next_cycle();
        reset_n = 1'b1;
        next_cycle();
        n_vec++;
        if ({busy, in_ready, mac_en, done} !== 4'b0) begin
            n_err++; $display("FAIL idle_after_reset: got %b want 0000",
                              {busy, in_ready, mac_en, done});
        end
    endtask

    task automatic test_len8();
        set_beat(0, 8'd1, 8'd2, 8'd3, 8'd4);
        set_beat(1, 8'd5, 8'd6, 8'd7, 8'd8);
        set_beat(2, -8'sd1, 8'd1, 8'd2, 8'd2);
        set_beat(3, 8'd0, 8'd9, 8'd4, -8'sd3);
        do_cmd(8, 0, 4, -1, 0);
        n_vec++;
        if (m_acc !== 24'sd91) begin
            n_err++; $display("FAIL len8_accum: got %0d want 91", m_acc);
        end
        n_vec++;
        if (done_cnt !== 1 || done_cyc - s_cyc !== 6) begin
            n_err++; $display("FAIL len8_done: got cnt=%0d at S+%0d want cnt=1 at S+6",
                              done_cnt, done_cyc - s_cyc);
        end
        n_vec++;
        if (load_cnt !== 1 || load_cyc - s_cyc !== 2) begin
            n_err++; $display("FAIL len8_load: got cnt=%0d at S+%0d want cnt=1 at S+2",
                              load_cnt, load_cyc - s_cyc);
        end
        n_vec++;
        if (en_cnt !== 5) begin
            n_err++; $display("FAIL len8_en_cycles: got %0d want 5", en_cnt);
        end
    endtask

    task automatic test_odd_len3();
        set_beat(0, 8'd10, 8'd10, 8'd2, 8'd3);
        set_beat(1, 8'd4, 8'd5, 8'h7F, 8'h7F);
        do_cmd(3, 1000, 2, -1, 0);
        n_vec++;
        if (m_acc !== 24'sd1126) begin
            n_err++; $display("FAIL len3_accum: got %0d want 1126", m_acc);
        end
        n_vec++;
        if (done_cnt !== 1 || done_cyc - s_cyc !== 4) begin
            n_err++; $display("FAIL len3_done: got cnt=%0d at S+%0d want cnt=1 at S+4",
                              done_cnt, done_cyc - s_cyc);
        end
        n_vec++;
        if (load_cnt !== 1 || load_cyc - s_cyc !== 2) begin
            n_err++; $display("FAIL len3_load: got cnt=%0d at S+%0d want cnt=1 at S+2",
                              load_cnt, load_cyc - s_cyc);
        end
    endtask

    task automatic test_len1();
        set_beat(0, -8'sd8, 8'd7, 8'h55, 8'h66);
        do_cmd(1, -5, 1, -1, 0);
        n_vec++;
        if (m_acc !== -24'sd61) begin
            n_err++; $display("FAIL len1_accum: got %0d want -61", m_acc);
        end
        n_vec++;
        if (done_cnt !== 1 || done_cyc - s_cyc !== 3) begin
            n_err++; $display("FAIL len1_done: got cnt=%0d at S+%0d want cnt=1 at S+3",
                              done_cnt, done_cyc - s_cyc);
        end
        n_vec++;
        if (load_cnt !== 1 || load_cyc - s_cyc !== 2) begin
            n_err++; $display("FAIL len1_load_in_drain: got cnt=%0d at S+%0d want cnt=1 at S+2",
                              load_cnt, load_cyc - s_cyc);
        end
    endtask

    task automatic test_len0();
        do_cmd(0, 42, 0, -1, 0);
        n_vec++;
        if (m_acc !== 24'sd42) begin
            n_err++; $display("FAIL len0_accum: got %0d want 42", m_acc);
        end
        n_vec++;
        if (rdy_cnt !== 0) begin
            n_err++; $display("FAIL len0_in_ready: got %0d ready cycles want 0", rdy_cnt);
        end
        n_vec++;
        if (done_cnt !== 1 || done_cyc - s_cyc !== 3) begin
            n_err++; $display("FAIL len0_done: got cnt=%0d at S+%0d want cnt=1 at S+3",
                              done_cnt, done_cyc - s_cyc);
        end
    endtask

    task automatic test_stall();
        set_beat(0, 8'd1, 8'd2, 8'd3, 8'd4);
        set_beat(1, 8'd5, 8'd6, 8'd7, 8'd8);
        do_cmd(4, 0, 2, 1, 3);
        n_vec++;
        if (m_acc !== 24'sd100) begin
            n_err++; $display("FAIL stall_accum: got %0d want 100", m_acc);
        end
        n_vec++;
        if (done_cnt !== 1 || done_cyc - s_cyc !== 7) begin
            n_err++; $display("FAIL stall_done: got cnt=%0d at S+%0d want cnt=1 at S+7",
                              done_cnt, done_cyc - s_cyc);
        end
        n_vec++;
        if (en_cnt !== 3) begin
            n_err++; $display("FAIL stall_en_cycles: got %0d want 3", en_cnt);
        end
        n_vec++;
        if (load_cyc - s_cyc !== 5) begin
            n_err++; $display("FAIL stall_load: got S+%0d want S+5", load_cyc - s_cyc);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        start = 1'b1; vec_len = LW'(2); bias = '0;
        next_cycle();
        start = 1'b0;
        in_valid = 1'b1; in_act = {8'd1, 8'd1}; in_w = {8'd1, 8'd1};
        next_cycle();
        in_valid = 1'b0; in_act = '0; in_w = '0;
        next_cycle();
        n_vec++;
        if (done !== 1'b1 || m_acc !== 24'sd2) begin
            n_err++; $display("FAIL b2b_first: got done=%b accum=%0d want done=1 accum=2",
                              done, m_acc);
        end
        start = 1'b1; vec_len = LW'(2); bias = AW'(10);
        next_cycle();
        start = 1'b0;
        in_valid = 1'b1; in_act = {8'd2, 8'd2}; in_w = {8'd2, 8'd2};
        next_cycle();
        in_valid = 1'b0; in_act = '0; in_w = '0;
        for (int k = 0; k < 20 && done_cnt < 2; k++) next_cycle();
        n_vec++;
        if (s_cyc !== first_done) begin
            n_err++; $display("FAIL b2b_start_in_fin: got S=%0d want %0d", s_cyc, first_done);
        end
        n_vec++;
        if (done_cnt !== 2 || done_cyc - s_cyc !== 3) begin
            n_err++; $display("FAIL b2b_done: got cnt=%0d at S+%0d want cnt=2 at S+3",
                              done_cnt, done_cyc - s_cyc);
        end
        n_vec++;
        if (m_acc !== 24'sd18) begin
            n_err++; $display("FAIL b2b_accum: got %0d want 18", m_acc);
        end
    endtask

    task automatic test_reset_mid_run();
        clear_mon();
        start = 1'b1; vec_len = LW'(8); bias = AW'(7);
        next_cycle();
        start = 1'b0;
        in_valid = 1'b1; in_act = 16'h0302; in_w = 16'h0405;
        next_cycle();
        next_cycle();
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, in_ready, mac_en, mac_load_accum, done} !== 5'b0) begin
            n_err++; $display("FAIL midrun_reset_ctrl: got %b want 00000",
                              {busy, in_ready, mac_en, mac_load_accum, done});
        end
        n_vec++;
        if ({mac_act, mac_w, mac_accum_prev} !== '0) begin
            n_err++; $display("FAIL midrun_reset_data: got %h want 0",
                              {mac_act, mac_w, mac_accum_prev});
        end
        in_valid = 1'b0; in_act = '0; in_w = '0;
        next_cycle();
        reset_n = 1'b1;
        repeat (5) next_cycle();
        n_vec++;
        if (done_cnt !== 0) begin
            n_err++; $display("FAIL midrun_no_done: got %0d done pulses want 0", done_cnt);
        end
        set_beat(0, 8'd3, 8'd3, 8'd3, 8'd3);
        do_cmd(2, 0, 1, -1, 0);
        n_vec++;
        if (m_acc !== 24'sd18 || done_cyc - s_cyc !== 3) begin
            n_err++; $display("FAIL post_reset_cmd: got accum=%0d done S+%0d want 18 at S+3",
                              m_acc, done_cyc - s_cyc);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; vec_len = '0; bias = '0;
        in_valid = 1'b0; in_act = '0; in_w = '0;
        clear_mon();
        #2;
        test_reset();
        test_len8();
        test_odd_len3();
        test_len1();
        test_len0();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
        repeat (2) next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
